// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: store sequencer. Runs the read-modify-write that a sub-word
// store (sh/sb) needs and the single write that a full-word store (sw) needs,
// behind one start/done handshake.
// Optional feature macro: STORE_BYPASS_EN adds a one-entry cache of the last
// written word. A sub-word store that hits this entry skips the memory read.
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ss_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       regb,
  input  logic              flush,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] SS_SW   = 2'b01;
  localparam logic [1:0] SS_SH   = 2'b11;
  localparam logic [1:0] SS_SB   = 2'b10;
  localparam logic [1:0] SS_ILL  = 2'b00;
  localparam logic [2:0] RD_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] mdr;
  logic [31:0] regb_q;
  logic [1:0]  op_q;
  logic [2:0]  rd_cnt;
  logic        hit;
  logic [31:0] byp_data;
  logic [ADDR_W-1:0] word_addr;

  // Sub-word data always lands in the low bits, whatever addr[1:0] says.
  function automatic logic [31:0] merge(input logic [1:0] op,
                                        input logic [31:0] base,
                                        input logic [31:0] data);
    case (op)
      SS_SH:   merge = {base[31:16], data[15:0]};
      SS_SB:   merge = {base[31:8],  data[7:0]};
      default: merge = data;
    endcase
  endfunction

  // Masking instead of slicing keeps every address bit in the logic cone.
  assign word_addr = addr & ~ADDR_W'(3);

  // Write data is a pure function of registered state, so it is stable for the whole WRITE cycle.
  assign mem_wdata = (state == WRITE) ? merge(op_q, mdr, regb_q) : 32'h0;

`ifdef STORE_BYPASS_EN
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;
  logic [31:0]       byp_word;

  // A flush in the accept cycle wins over a hit, so stale data is never merged.
  assign hit      = byp_valid && (byp_addr == word_addr) && !flush;
  assign byp_data = byp_word;

  // The bypass entry tracks the last written word; flush beats a same-cycle update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_valid <= 1'b0;
      byp_addr  <= '0;
      byp_word  <= 32'h0;
    end else if (flush) begin
      byp_valid <= 1'b0;
    end else if (state == WRITE) begin
      byp_valid <= 1'b1;
      byp_addr  <= mem_addr;
      byp_word  <= mem_wdata;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign byp_data     = 32'h0;
`endif

  // Sequencer: state, latched operands and registered memory/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mdr      <= 32'h0;
      regb_q   <= 32'h0;
      op_q     <= 2'b00;
      rd_cnt   <= 3'd0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            regb_q <= regb;
            op_q   <= ss_ctrl;
            rd_cnt <= 3'd0;
            busy   <= 1'b1;
            if (ss_ctrl == SS_ILL) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (ss_ctrl == SS_SW || hit) begin
              state    <= WRITE;
              mem_wr   <= 1'b1;
              mem_addr <= word_addr;
              mdr      <= byp_data;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= word_addr;
            end
          end
        end
        READ: begin
          if (rd_cnt == RD_LAST) begin
            mdr    <= mem_rdata;
            mem_rd <= 1'b0;
            mem_wr <= 1'b1;
            state  <= WRITE;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        WRITE: begin
          mem_wr   <= 1'b0;
          mem_addr <= '0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Testbench for store_rmw_ctrl: directed steps followed by random stores,
// checked against a word-array memory model and store-merge rules.
module tb_store_rmw_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  ss_ctrl = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] regb = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr, busy, done, err;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int          checks = 0;
  int          failures = 0;
  int          rdc = 0;
  bit          byp_v = 0;
  logic [31:0] byp_a = 32'h0;

  always #5 clk = ~clk;

  store_rmw_ctrl #(.MEM_LAT(L), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ss_ctrl(ss_ctrl), .addr(addr),
    .regb(regb), .flush(flush), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and play the memory: commit writes,
  // present read data only on the L-th consecutive read cycle.
  task automatic cyc();
    @(negedge clk);
    if (mem_wr === 1'b1) mem[mem_addr[6:2]] = mem_wdata;
    if (mem_rd === 1'b1) rdc++; else rdc = 0;
    if (mem_rd === 1'b1 && rdc == L) mem_rdata = mem[mem_addr[6:2]];
    else mem_rdata = $urandom;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    byp_v = 0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input bit noise, input string tag);
    logic [31:0] wa, base, exp_wd, wd_seen, wa_seen, errv;
    int idx, exp_rd, exp_wr, exp_done;
    int wr_cyc, rd_first, rd_n, wr_n, done_cyc;
    bit hit, legal, both, busy_bad, addr_bad, done_addr_bad;
    wa = a & ~32'd3;
    idx = int'(wa[6:2]);
    base = ref_mem[idx];
    hit = 0;
`ifdef STORE_BYPASS_EN
    hit = byp_v && (byp_a == wa);
`endif
    legal = (op != 2'b00);
    wr_cyc = -1; rd_first = -1; rd_n = 0; wr_n = 0; done_cyc = -1;
    wd_seen = 0; wa_seen = 0; errv = 0;
    both = 0; busy_bad = 0; addr_bad = 0; done_addr_bad = 0;
    case (op)
      2'b01:   begin exp_wd = d; exp_rd = 0; end
      2'b11:   begin exp_wd = {base[31:16], d[15:0]}; exp_rd = hit ? 0 : L; end
      2'b10:   begin exp_wd = {base[31:8], d[7:0]};   exp_rd = hit ? 0 : L; end
      default: begin exp_wd = 0; exp_rd = 0; end
    endcase
    exp_wr   = legal ? exp_rd + 1 : -1;
    exp_done = legal ? exp_rd + 2 : 1;

    start = 1'b1; ss_ctrl = op; addr = a; regb = d;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (noise) begin
        start = 1'($urandom_range(0, 1)); ss_ctrl = 2'($urandom);
        addr = $urandom_range(0, 127); regb = $urandom;
      end else begin
        start = 1'b0;
      end
      if (mem_rd === 1'b1 && mem_wr === 1'b1) both = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (mem_rd === 1'b1) begin
        rd_n++;
        if (rd_first < 0) rd_first = k;
        if (mem_addr !== wa) addr_bad = 1;
      end
      if (mem_wr === 1'b1) begin
        wr_n++; wr_cyc = k; wd_seen = mem_wdata; wa_seen = mem_addr;
      end
      if (done === 1'b1) begin
        done_cyc = k; errv = {31'h0, err};
        if (mem_addr !== 32'h0) done_addr_bad = 1;
        break;
      end
    end
    check({tag, "/done_cycle"}, done_cyc, exp_done);
    check({tag, "/err"}, errv, legal ? 32'h0 : 32'h1);
    check({tag, "/rd_cycles"}, rd_n, exp_rd);
    check({tag, "/rd_first"}, rd_first, exp_rd > 0 ? 1 : -1);
    check({tag, "/wr_count"}, wr_n, legal ? 1 : 0);
    check({tag, "/wr_cycle"}, wr_cyc, exp_wr);
    if (legal) begin
      check({tag, "/wdata"}, wd_seen, exp_wd);
      check({tag, "/waddr"}, wa_seen, wa);
    end
    check({tag, "/rd_and_wr"}, both, 0);
    check({tag, "/busy_held"}, busy_bad, 0);
    check({tag, "/rd_addr"}, addr_bad, 0);
    check({tag, "/done_addr_zero"}, done_addr_bad, 0);
    if (legal) begin
      ref_mem[idx] = exp_wd;
      byp_v = 1;
      byp_a = wa;
    end
    start = 1'b0;
    cyc();
    check({tag, "/idle_after"}, {busy, done, err, mem_rd, mem_wr}, 0);
  endtask

  initial begin
    logic [31:0] r;
    bit wr_seen;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state
    cyc(); cyc();
    check("reset/ctrl", {busy, done, err, mem_rd, mem_wr}, 0);
    check("reset/addr", mem_addr, 0);
    check("reset/wdata", mem_wdata, 0);
    reset = 1'b1;
    cyc();

    // Directed cases from the plan
    run_op(2'b01, 32'h40, 32'hDEADBEEF, 0, "sw40");
    mem[17] = 32'h11223344; ref_mem[17] = 32'h11223344;
    run_op(2'b11, 32'h46, 32'hAAAABBBB, 0, "sh46");
    check("sh46/mem", mem[17], 32'h1122BBBB);
    mem[18] = 32'h11223344; ref_mem[18] = 32'h11223344;
    run_op(2'b10, 32'h4B, 32'h000000CC, 1, "sb4b_noise");
    check("sb4b/mem", mem[18], 32'h112233CC);
    run_op(2'b00, 32'h10, 32'h12345678, 0, "illegal");
    run_op(2'b01, 32'h14, 32'h0BADF00D, 0, "sw_after_illegal");

`ifdef STORE_BYPASS_EN
    run_op(2'b01, 32'h48, 32'h11223344, 0, "byp_sw");
    run_op(2'b10, 32'h48, 32'h00000055, 0, "byp_sb_hit");
    check("byp_sb_hit/mem", mem[18], 32'h11223355);
    do_flush();
    run_op(2'b10, 32'h48, 32'h00000055, 0, "byp_sb_flushed");
`endif

    // Reset in the middle of a read
    start = 1'b1; ss_ctrl = 2'b11; addr = 32'h50; regb = 32'hCAFEF00D;
    cyc();
    start = 1'b0;
    check("rst_mid/in_read", {30'h0, mem_rd, busy}, 32'h3);
    #2 reset = 1'b0;
    #1;
    check("rst_mid/ctrl", {busy, done, err, mem_rd, mem_wr}, 0);
    check("rst_mid/addr", mem_addr, 0);
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (mem_wr !== 1'b0) wr_seen = 1;
    end
    reset = 1'b1;
    byp_v = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (mem_wr !== 1'b0) wr_seen = 1;
    end
    check("rst_mid/no_write", wr_seen, 0);
    check("rst_mid/mem_kept", mem[20], ref_mem[20]);
    run_op(2'b01, 32'h50, 32'h600DCAFE, 0, "sw_after_reset");

    // Random stores against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) do_flush();
      run_op(r == 0 ? 2'b00 : (r < 4 ? 2'b01 : (r < 7 ? 2'b11 : 2'b10)),
             $urandom_range(0, 127), $urandom, 1'($urandom_range(0, 1)), "rand");
    end
    for (int i = 0; i < 32; i++) begin
      if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
    end
    check("final_mem_word0", mem[0], ref_mem[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
